// File: rtl/bram_burst_pkg.sv
// Shared types and bit offsets for the BRAM burst initiator.
package bram_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Packed RAM request {addr, data, wr}
  localparam int WR_BIT   = 0;
  localparam int DATA_LSB = 1;

  // Command {fill, count, base, is_write}
  localparam int CMD_WR_BIT   = 0;
  localparam int CMD_BASE_LSB = 1;

  function automatic int addr_lsb(input int width);
    return width + 1;
  endfunction

  function automatic int cmd_count_lsb(input int addr_width);
    return 1 + addr_width;
  endfunction

  function automatic int cmd_fill_lsb(input int addr_width, input int count_width);
    return 1 + addr_width + count_width;
  endfunction

endpackage

// File: rtl/bram_outstanding_ctr.sv
// Saturating up/down count of requests accepted but not yet answered.
module bram_outstanding_ctr #(
  parameter int MaxOutstanding = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [CntW-1:0] cnt_r;

  // Count register: simultaneous inc/dec cancels; decrement floors at zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_r <= {CntW{1'b0}};
    end else if (inc && !dec && !full) begin
      cnt_r <= cnt_r + CntW'(1);
    end else if (dec && !inc && !empty) begin
      cnt_r <= cnt_r - CntW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign full  = (cnt_r == CntW'(MaxOutstanding));
  assign empty = (cnt_r == {CntW{1'b0}});

endmodule

// File: rtl/bram_burst_initiator.sv
// Burst initiator on the valid/bp block-RAM port protocol.
// Optional sticky error output enabled by BRAM_BURST_INITIATOR_ERR_EN.
module bram_burst_initiator
  import bram_burst_pkg::*;
#(
  parameter int Width          = 8,
  parameter int AddrWidth      = 8,
  parameter int CountWidth     = 8,
  parameter int MaxOutstanding = 4
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [AddrWidth+CountWidth+Width:0] cmd,
  input  logic                              cmd_valid,
  output logic                              cmd_bp,
  output logic [Width+AddrWidth:0]          mem_req,
  output logic                              mem_req_valid,
  input  logic                              mem_req_bp,
  input  logic [Width-1:0]                  mem_resp,
  input  logic                              mem_resp_valid,
  output logic                              mem_resp_bp,
  output logic [Width-1:0]                  rd_data,
  output logic                              rd_valid,
  input  logic                              rd_bp,
  output logic                              done
`ifdef BRAM_BURST_INITIATOR_ERR_EN
  ,
  output logic                              err
`endif
);

  localparam int AddrLsb = addr_lsb(Width);
  localparam int CntLsb  = cmd_count_lsb(AddrWidth);
  localparam int FillLsb = cmd_fill_lsb(AddrWidth, CountWidth);

  state_e                state_r, state_nxt_s;
  logic                  is_write_r;
  logic [AddrWidth-1:0]  addr_r;
  logic [CountWidth-1:0] count_r;
  logic [CountWidth-1:0] issued_r;
  logic [Width-1:0]      fill_r;
  logic                  done_r;

  logic                  cmd_bp_s, mem_req_valid_s, read_active_s, mem_resp_bp_s;
  logic                  cmd_acc_s, req_acc_s, resp_acc_s, last_req_s;
  logic                  ctr_full_s, ctr_empty_s;
  logic                  cmd_wr_s;
  logic [AddrWidth-1:0]  cmd_base_s;
  logic [CountWidth-1:0] cmd_count_s;
  logic [Width-1:0]      cmd_fill_s;
  logic [Width+AddrWidth:0] mem_req_s;

  assign cmd_wr_s    = cmd[CMD_WR_BIT];
  assign cmd_base_s  = cmd[CMD_BASE_LSB +: AddrWidth];
  assign cmd_count_s = cmd[CntLsb +: CountWidth];
  assign cmd_fill_s  = cmd[FillLsb +: Width];

  assign cmd_acc_s  = cmd_valid && !cmd_bp_s;
  assign req_acc_s  = mem_req_valid_s && !mem_req_bp;
  assign resp_acc_s = mem_resp_valid && !mem_resp_bp_s;
  assign last_req_s = req_acc_s && (issued_r == (count_r - CountWidth'(1)));

  bram_outstanding_ctr #(
    .MaxOutstanding(MaxOutstanding)
  ) u_ctr (
    .clk   (clk),
    .resetn(resetn),
    .inc   (req_acc_s),
    .dec   (resp_acc_s),
    .full  (ctr_full_s),
    .empty (ctr_empty_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; a zero-length command never leaves IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_acc_s && (cmd_count_s != {CountWidth{1'b0}})) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (last_req_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      DRAIN: begin
        if (ctr_empty_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from state; response routing follows the latched op.
  always_comb begin
    cmd_bp_s        = 1'b1;
    mem_req_valid_s = 1'b0;
    read_active_s   = 1'b0;
    case (state_r)
      IDLE: begin
        cmd_bp_s = 1'b0;
      end
      ISSUE: begin
        mem_req_valid_s = (issued_r < count_r) && !ctr_full_s;
        read_active_s   = !is_write_r;
      end
      DRAIN: begin
        read_active_s = !is_write_r;
      end
      default: begin
        cmd_bp_s = 1'b0;
      end
    endcase
  end

  // Burst datapath: command latch, address walk, done pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      is_write_r <= 1'b0;
      addr_r     <= {AddrWidth{1'b0}};
      count_r    <= {CountWidth{1'b0}};
      issued_r   <= {CountWidth{1'b0}};
      fill_r     <= {Width{1'b0}};
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_acc_s) begin
            is_write_r <= cmd_wr_s;
            addr_r     <= cmd_base_s;
            count_r    <= cmd_count_s;
            fill_r     <= cmd_fill_s;
            issued_r   <= {CountWidth{1'b0}};
            done_r     <= (cmd_count_s == {CountWidth{1'b0}});
          end
        end
        ISSUE: begin
          if (req_acc_s) begin
            addr_r   <= addr_r + AddrWidth'(1);
            issued_r <= issued_r + CountWidth'(1);
          end
        end
        DRAIN: begin
          done_r <= ctr_empty_s;
        end
        default: done_r <= 1'b0;
      endcase
    end
  end

  // Request packing at the package offsets.
  always_comb begin
    mem_req_s                        = {(Width+AddrWidth+1){1'b0}};
    mem_req_s[WR_BIT]                = is_write_r;
    mem_req_s[DATA_LSB +: Width]     = fill_r;
    mem_req_s[AddrLsb +: AddrWidth]  = addr_r;
  end

  assign mem_resp_bp_s = read_active_s ? rd_bp : 1'b0;

  assign cmd_bp        = cmd_bp_s;
  assign mem_req       = mem_req_s;
  assign mem_req_valid = mem_req_valid_s;
  assign mem_resp_bp   = mem_resp_bp_s;
  assign rd_data       = mem_resp;
  assign rd_valid      = read_active_s && mem_resp_valid;
  assign done          = done_r;

`ifdef BRAM_BURST_INITIATOR_ERR_EN
  logic [AddrWidth+CountWidth+Width:0] cmd_prev_r;
  logic                                err_r;
  logic                                stray_s;

  // A stray is a response accepted with nothing in flight and no issue alongside.
  assign stray_s = resp_acc_s && !req_acc_s && ctr_empty_s;

  // Sticky protocol error: stray response or command changed while stalled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cmd_prev_r <= {(AddrWidth+CountWidth+Width+1){1'b0}};
      err_r      <= 1'b0;
    end else begin
      cmd_prev_r <= cmd;
      if (stray_s || (cmd_valid && cmd_bp_s && (cmd != cmd_prev_r))) begin
        err_r <= 1'b1;
      end
    end
  end

  assign err = err_r;
`endif

endmodule

// File: tb/tb_bram_burst_initiator.sv
// Self-checking bench for bram_burst_initiator with a latency-configurable RAM model.
// Build with BRAM_BURST_INITIATOR_ERR_EN to also check the err output.
module tb_bram_burst_initiator;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [24:0] cmd = 25'd0;
  logic        cmd_valid = 1'b0;
  logic        cmd_bp;
  logic [16:0] mem_req;
  logic        mem_req_valid;
  logic        mem_req_bp;
  logic [7:0]  mem_resp;
  logic        mem_resp_valid;
  logic        mem_resp_bp;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_bp = 1'b0;
  logic        done;
`ifdef BRAM_BURST_INITIATOR_ERR_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  bram_burst_initiator #(
    .Width(8), .AddrWidth(8), .CountWidth(8), .MaxOutstanding(2)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_bp(cmd_bp),
    .mem_req(mem_req), .mem_req_valid(mem_req_valid), .mem_req_bp(mem_req_bp),
    .mem_resp(mem_resp), .mem_resp_valid(mem_resp_valid), .mem_resp_bp(mem_resp_bp),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_bp(rd_bp),
    .done(done)
`ifdef BRAM_BURST_INITIATOR_ERR_EN
    , .err(err)
`endif
  );

  // RAM model: lat==0 is a combinational port, otherwise an in-order response queue.
  int         lat = 0;
  int         cyc = 0;
  logic       stray = 1'b0;
  logic       pl_we = 1'b0;
  logic [7:0] pl_addr = 8'd0;
  logic [7:0] pl_data = 8'd0;
  logic [7:0] mem [0:255];
  logic [7:0] q_data [0:15];
  int         q_rdy [0:15];
  logic [3:0] q_wp = 4'd0;
  logic [3:0] q_rp = 4'd0;
  logic [7:0] req_addr, req_data;
  logic       req_acc, q_nonempty, pop;

  assign req_addr   = mem_req[16:9];
  assign req_data   = mem_req[8:1];
  assign req_acc    = mem_req_valid && !mem_req_bp;
  assign q_nonempty = (q_wp != q_rp);
  assign mem_req_bp = (lat == 0) ? mem_resp_bp : 1'b0;
  assign mem_resp_valid = stray ||
      ((lat == 0) ? mem_req_valid : (q_nonempty && (q_rdy[q_rp] <= cyc)));
  assign mem_resp   = (lat == 0) ? mem[req_addr] : q_data[q_rp];
  assign pop        = (lat != 0) && q_nonempty && mem_resp_valid && !mem_resp_bp;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_we) mem[pl_addr] <= pl_data;
    if (req_acc && mem_req[0]) mem[req_addr] <= req_data;
    if (req_acc && lat != 0) begin
      q_data[q_wp] <= mem[req_addr];
      q_rdy[q_wp]  <= cyc + lat;
    end
    if (!resetn) begin
      q_rp <= q_wp;
    end else begin
      if (req_acc && lat != 0) q_wp <= q_wp + 4'd1;
      if (pop) q_rp <= q_rp + 4'd1;
    end
  end

  // Transaction monitor.
  logic       clr = 1'b0;
  int         nreq, nrsp, nrd, ndone, inflight, maxinf, rsp_at_done;
  logic [7:0] last_addr;
  logic       last_wr;
  logic [7:0] rd_log [0:15];

  always @(posedge clk) begin
    if (clr) begin
      nreq <= 0; nrsp <= 0; nrd <= 0; ndone <= 0;
      inflight <= 0; maxinf <= 0; rsp_at_done <= -1;
      last_addr <= 8'd0; last_wr <= 1'b0;
    end else begin
      if (req_acc) begin
        nreq <= nreq + 1;
        last_addr <= req_addr;
        last_wr <= mem_req[0];
      end
      if (mem_resp_valid && !mem_resp_bp) nrsp <= nrsp + 1;
      if (rd_valid && !rd_bp) begin
        rd_log[nrd % 16] <= rd_data;
        nrd <= nrd + 1;
      end
      if (done) begin
        ndone <= ndone + 1;
        rsp_at_done <= nrsp;
      end
      inflight <= inflight + (req_acc ? 1 : 0) - ((mem_resp_valid && !mem_resp_bp) ? 1 : 0);
      if (inflight > maxinf) maxinf <= inflight;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic run_burst(input logic wr, input logic [7:0] base,
                           input logic [7:0] count, input logic [7:0] fill);
    @(negedge clk);
    cmd = {fill, count, base, wr};
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!cmd_bp) break;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int start;
    int to;
    start = ndone;
    to = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ndone > start) begin
        to = 0;
        break;
      end
    end
    check({nm, "_timeout"}, to, 0);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] base;
    logic [7:0] count;
    logic [7:0] fill;
    int         lat;
    int         exp_nrd;
    logic [7:0] exp_last_addr;
    logic [7:0] exp_rd_first;
    logic [7:0] exp_rd_last;
    int         exp_maxinf;
  } vec_t;

  vec_t vecs [0:5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 8'hFE, 8'd4, 8'hA5, 0, 0, 8'h01, 8'h00, 8'h00, 0};
    vecs[1] = '{1'b0, 8'h10, 8'd3, 8'h00, 0, 3, 8'h12, 8'h11, 8'h33, 0};
    vecs[2] = '{1'b0, 8'h00, 8'd1, 8'h00, 0, 1, 8'h00, 8'hA5, 8'hA5, 0};
    vecs[3] = '{1'b0, 8'h10, 8'd6, 8'h00, 3, 6, 8'h15, 8'h11, 8'h66, 2};
    vecs[4] = '{1'b1, 8'h80, 8'd2, 8'h3C, 1, 0, 8'h81, 8'h00, 8'h00, 1};
    vecs[5] = '{1'b0, 8'hFF, 8'd2, 8'h00, 0, 2, 8'h00, 8'hA5, 8'hA5, 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_bp", cmd_bp, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
`ifdef BRAM_BURST_INITIATOR_ERR_EN
    check("rst_err", err, 0);
`endif
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pl_we = 1'b1;
      pl_addr = 8'h10 + 8'(i);
      pl_data = 8'(8'h11 * (i + 1));
    end
    @(negedge clk);
    pl_we = 1'b0;

    // Table-driven bursts
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      lat = vecs[v].lat;
      run_burst(vecs[v].wr, vecs[v].base, vecs[v].count, vecs[v].fill);
      wait_done($sformatf("v%0d", v));
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_nreq", v), nreq, int'(vecs[v].count));
      check($sformatf("v%0d_ndone", v), ndone, 1);
      check($sformatf("v%0d_nrd", v), nrd, vecs[v].exp_nrd);
      check($sformatf("v%0d_last_addr", v), last_addr, vecs[v].exp_last_addr);
      check($sformatf("v%0d_last_wr", v), last_wr, vecs[v].wr);
      check($sformatf("v%0d_rsp_at_done", v), rsp_at_done, int'(vecs[v].count));
      check($sformatf("v%0d_max_inflight", v), maxinf, vecs[v].exp_maxinf);
      if (vecs[v].exp_nrd > 0) begin
        check($sformatf("v%0d_rd_first", v), rd_log[0], vecs[v].exp_rd_first);
        check($sformatf("v%0d_rd_last", v), rd_log[(nrd - 1) % 16], vecs[v].exp_rd_last);
      end
    end

    // Read stream stalled by rd_bp for 5 cycles
    begin
      int n0;
      clear_mon();
      lat = 1;
      run_burst(1'b0, 8'h10, 8'd6, 8'h00);
      for (int i = 0; i < 100; i++) begin
        if (nrd >= 2) break;
        @(negedge clk);
      end
      rd_bp = 1'b1;
      n0 = nrd;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("stall_resp_bp", mem_resp_bp, 1);
        if (k >= 2) check("stall_req_valid", mem_req_valid, 0);
      end
      check("stall_no_data", nrd, n0);
      rd_bp = 1'b0;
      wait_done("stall");
      repeat (2) @(negedge clk);
      check("stall_nrd", nrd, 6);
      check("stall_ndone", ndone, 1);
      for (int i = 0; i < 6; i++)
        check($sformatf("stall_rd%0d", i), rd_log[i], int'(8'(8'h11 * (i + 1))));
    end

    // Zero-length command
    clear_mon();
    lat = 0;
    @(negedge clk);
    cmd = {8'h77, 8'd0, 8'h20, 1'b0};
    cmd_valid = 1'b1;
    check("cnt0_cmd_bp", cmd_bp, 0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cnt0_done_hi", done, 1);
    check("cnt0_req_valid", mem_req_valid, 0);
    @(negedge clk);
    check("cnt0_done_lo", done, 0);
    repeat (2) @(negedge clk);
    check("cnt0_nreq", nreq, 0);
    check("cnt0_ndone", ndone, 1);

    // Command offered during ISSUE is held off
    clear_mon();
    lat = 3;
    run_burst(1'b0, 8'h10, 8'd6, 8'h00);
    cmd = {8'h99, 8'd2, 8'h40, 1'b1};
    cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("busy_cmd_bp", cmd_bp, 1);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    wait_done("busy");
    repeat (4) @(negedge clk);
    check("busy_nreq", nreq, 6);
    check("busy_ndone", ndone, 1);
`ifdef BRAM_BURST_INITIATOR_ERR_EN
    check("busy_err", err, 1);
`endif

    // Reset during the 3rd request of an 8-word burst
    clear_mon();
    lat = 3;
    run_burst(1'b1, 8'h40, 8'd8, 8'h5A);
    for (int i = 0; i < 200; i++) begin
      if (nreq == 2 && mem_req_valid) break;
      @(negedge clk);
    end
    check("mid_third_req", mem_req_valid, 1);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_cmd_bp", cmd_bp, 0);
    check("mid_req_valid", mem_req_valid, 0);
    check("mid_rd_valid", rd_valid, 0);
    check("mid_done", done, 0);
`ifdef BRAM_BURST_INITIATOR_ERR_EN
    check("mid_err_clr", err, 0);
`endif
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_no_done", ndone, 0);
    check("mid_dropped", mem_req_valid, 0);

    // Stray response in IDLE
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
`ifdef BRAM_BURST_INITIATOR_ERR_EN
    check("stray_err", err, 1);
`endif
    clear_mon();
    lat = 0;
    run_burst(1'b0, 8'h10, 8'd1, 8'h00);
    wait_done("post_stray");
    repeat (2) @(negedge clk);
    check("post_stray_nrd", nrd, 1);
    check("post_stray_rd", rd_log[0], 8'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
